// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises RX, tracks start/data/parity/stop bits on
// oversample ticks and holds the received byte plus sticky error status for uart_regs.
module uart_rx_ctrl #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       rx_sample_pulse,
    input  logic       RX,
    input  logic       data_bits,
    input  logic       parity_en,
    input  logic       parity_odd0_even1,
    input  logic       rx_data_reg_rd,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    localparam int unsigned TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [TW-1:0]          tick_cnt, tick_nxt;
    logic [3:0]             bit_cnt, bit_nxt;
    logic [7:0]             shreg, shreg_nxt;
    logic                   par_acc, par_acc_nxt;
    logic                   perr_seen, perr_seen_nxt;
    logic                   armed, armed_nxt;
    logic                   cfg_8bit, cfg_8bit_nxt;
    logic                   cfg_pen, cfg_pen_nxt;
    logic                   cfg_even, cfg_even_nxt;
    logic                   sample, last_bit;
    logic                   frame_ok, frame_bad;
    logic [7:0]             frame_byte;
    logic [7:0]             data_nxt;
    logic                   ready_nxt, perr_nxt, ferr_nxt, ovf_nxt;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], RX};
        end
    end

    always_comb begin
        rxs = sync[SYNC_STAGES-1];
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            perr_seen <= 1'b0;
            armed     <= 1'b1;
            cfg_8bit  <= 1'b0;
            cfg_pen   <= 1'b0;
            cfg_even  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= shreg_nxt;
            par_acc   <= par_acc_nxt;
            perr_seen <= perr_seen_nxt;
            armed     <= armed_nxt;
            cfg_8bit  <= cfg_8bit_nxt;
            cfg_pen   <= cfg_pen_nxt;
            cfg_even  <= cfg_even_nxt;
        end
    end

    // After the START mid-bit check tick_cnt restarts at 0, so every later mid-bit
    // sample lands on the tick where tick_cnt is about to wrap.
    always_comb begin
        state_nxt     = state;
        tick_nxt      = tick_cnt;
        bit_nxt       = bit_cnt;
        shreg_nxt     = shreg;
        par_acc_nxt   = par_acc;
        perr_seen_nxt = perr_seen;
        armed_nxt     = armed;
        cfg_8bit_nxt  = cfg_8bit;
        cfg_pen_nxt   = cfg_pen;
        cfg_even_nxt  = cfg_even;
        frame_ok      = 1'b0;
        frame_bad     = 1'b0;
        sample        = (tick_cnt == LAST);
        last_bit      = cfg_8bit ? (bit_cnt == 4'd7) : (bit_cnt == 4'd6);

        if (rx_sample_pulse) begin
            case (state)
                IDLE: begin
                    if (rxs) begin
                        armed_nxt = 1'b1;
                    end else if (armed) begin
                        state_nxt     = START;
                        tick_nxt      = TW'(1);
                        bit_nxt       = '0;
                        par_acc_nxt   = 1'b0;
                        perr_seen_nxt = 1'b0;
                        cfg_8bit_nxt  = data_bits;
                        cfg_pen_nxt   = parity_en;
                        cfg_even_nxt  = parity_odd0_even1;
                    end
                end
                START: begin
                    if (tick_cnt == MID) begin
                        tick_nxt  = '0;
                        state_nxt = rxs ? IDLE : DATA;
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
                DATA: begin
                    tick_nxt = tick_cnt + TW'(1);
                    if (sample) begin
                        shreg_nxt   = {rxs, shreg[7:1]};
                        par_acc_nxt = par_acc ^ rxs;
                        bit_nxt     = bit_cnt + 4'd1;
                        if (last_bit) begin
                            state_nxt = cfg_pen ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    tick_nxt = tick_cnt + TW'(1);
                    if (sample) begin
                        perr_seen_nxt = ((par_acc ^ rxs) == cfg_even);
                        state_nxt     = STOP;
                    end
                end
                STOP: begin
                    tick_nxt = tick_cnt + TW'(1);
                    if (sample) begin
                        state_nxt = IDLE;
                        tick_nxt  = '0;
                        if (rxs) begin
                            frame_ok = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                            armed_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tick_nxt  = '0;
                end
            endcase
        end
    end

    // A read in the same cycle as frame completion is applied first, so the new
    // frame sees an empty holding register.
    always_comb begin
        frame_byte = cfg_8bit ? shreg : {1'b0, shreg[7:1]};
        data_nxt   = rx_data;
        ready_nxt  = rx_ready    & ~rx_data_reg_rd;
        perr_nxt   = parity_err  & ~rx_data_reg_rd;
        ferr_nxt   = framing_err & ~rx_data_reg_rd;
        ovf_nxt    = overflow    & ~rx_data_reg_rd;
        if (frame_bad) begin
            ferr_nxt = 1'b1;
        end
        if (frame_ok) begin
            if (!ready_nxt) begin
                data_nxt  = frame_byte;
                ready_nxt = 1'b1;
                perr_nxt  = perr_nxt | perr_seen;
            end else begin
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_data     <= '0;
            rx_ready    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            rx_data     <= data_nxt;
            rx_ready    <= ready_nxt;
            parity_err  <= perr_nxt;
            framing_err <= ferr_nxt;
            overflow    <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a table of frames plus hand-written corner sequences.
module tb_uart_rx_ctrl;

    logic       PCLK;
    logic       PRESET;
    logic       rx_sample_pulse;
    logic       RX;
    logic       data_bits;
    logic       parity_en;
    logic       parity_odd0_even1;
    logic       rx_data_reg_rd;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] d;
        bit         b8;
        bit         pen;
        bit         even;
        bit         pbit;
        bit         stop;
        bit         chg;
        logic [7:0] e_data;
        bit         e_rdy;
        bit         e_perr;
        bit         e_ferr;
        bit         e_ovf;
    } vec_t;

    vec_t vecs[7];

    uart_rx_ctrl #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .PCLK              (PCLK),
        .PRESET            (PRESET),
        .rx_sample_pulse   (rx_sample_pulse),
        .RX                (RX),
        .data_bits         (data_bits),
        .parity_en         (parity_en),
        .parity_odd0_even1 (parity_odd0_even1),
        .rx_data_reg_rd    (rx_data_reg_rd),
        .rx_data           (rx_data),
        .rx_ready          (rx_ready),
        .parity_err        (parity_err),
        .framing_err       (framing_err),
        .overflow          (overflow)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // One oversample tick every 4 PCLK cycles
    initial begin
        int div;
        div = 0;
        rx_sample_pulse = 1'b0;
        forever begin
            @(negedge PCLK);
            rx_sample_pulse = (div == 3);
            div = (div + 1) % 4;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input bit rdy,
                              input bit perr, input bit ferr, input bit ovf);
        check({tag, ".rx_data"},     rx_data,              d);
        check({tag, ".rx_ready"},    {7'b0, rx_ready},     {7'b0, rdy});
        check({tag, ".parity_err"},  {7'b0, parity_err},   {7'b0, perr});
        check({tag, ".framing_err"}, {7'b0, framing_err},  {7'b0, ferr});
        check({tag, ".overflow"},    {7'b0, overflow},     {7'b0, ovf});
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            do begin
                @(posedge PCLK);
                guard++;
            end while (!rx_sample_pulse && guard < 16);
        end
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d, input bit b8, input bit pen,
                             input bit pbit, input bit chg);
        logic [7:0] dv;
        dv = d;
        RX = 1'b0;
        wait_ticks(16);
        if (chg) begin
            data_bits         = ~data_bits;
            parity_en         = ~parity_en;
            parity_odd0_even1 = ~parity_odd0_even1;
        end
        for (int i = 0; i < (b8 ? 8 : 7); i++) begin
            RX = dv[i];
            wait_ticks(16);
        end
        if (pen) begin
            RX = pbit;
            wait_ticks(16);
        end
    endtask

    task automatic send_stop(input bit s);
        RX = s;
        wait_ticks(16);
        RX = 1'b1;
        wait_ticks(2);
    endtask

    task automatic send_8n1(input logic [7:0] d);
        data_bits = 1'b1;
        parity_en = 1'b0;
        send_bits(d, 1'b1, 1'b0, 1'b0, 1'b0);
        send_stop(1'b1);
    endtask

    task automatic do_read();
        @(negedge PCLK);
        rx_data_reg_rd = 1'b1;
        @(negedge PCLK);
        rx_data_reg_rd = 1'b0;
    endtask

    initial begin
        bit seen_low;
        bit done;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'hD5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0};

        PRESET            = 1'b1;
        RX                = 1'b1;
        data_bits         = 1'b1;
        parity_en         = 1'b0;
        parity_odd0_even1 = 1'b0;
        rx_data_reg_rd    = 1'b0;
        repeat (3) @(negedge PCLK);
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        PRESET = 1'b0;
        wait_ticks(4);

        for (int i = 0; i < 7; i++) begin
            do_read();
            check($sformatf("vec%0d.cleared_ready", i), {7'b0, rx_ready}, 8'h00);
            check($sformatf("vec%0d.cleared_ferr", i), {7'b0, framing_err}, 8'h00);
            data_bits         = vecs[i].b8;
            parity_en         = vecs[i].pen;
            parity_odd0_even1 = vecs[i].even;
            wait_ticks(2);
            send_bits(vecs[i].d, vecs[i].b8, vecs[i].pen, vecs[i].pbit, vecs[i].chg);
            send_stop(vecs[i].stop);
            check_outs($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_rdy,
                       vecs[i].e_perr, vecs[i].e_ferr, vecs[i].e_ovf);
        end

        // Short low glitch is a false start; a following frame must still be clean
        do_read();
        RX = 1'b0;
        wait_ticks(4);
        RX = 1'b1;
        wait_ticks(40);
        check_outs("glitch", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        send_8n1(8'h96);
        check_outs("after_glitch", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);

        // Two frames without a read
        do_read();
        send_8n1(8'h11);
        send_8n1(8'h22);
        check_outs("overflow", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        do_read();
        check_outs("overflow_read", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        // Read coinciding with frame completion
        data_bits         = 1'b1;
        parity_en         = 1'b1;
        parity_odd0_even1 = 1'b1;
        send_bits(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        send_stop(1'b1);
        check_outs("rdcomp_pre", 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        send_bits(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        RX = 1'b1;
        @(negedge PCLK);
        rx_data_reg_rd = 1'b1;
        seen_low = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 120 && !done; c++) begin
            @(negedge PCLK);
            if (rx_ready && seen_low) done = 1'b1;
            if (!rx_ready) seen_low = 1'b1;
        end
        rx_data_reg_rd = 1'b0;
        check("rdcomp.completed", {7'b0, done}, 8'h01);
        wait_ticks(10);
        check_outs("rdcomp", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);

        // Break: line held low well past the frame
        do_read();
        data_bits = 1'b1;
        parity_en = 1'b0;
        send_bits(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        RX = 1'b0;
        wait_ticks(64);
        check_outs("break", 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        RX = 1'b1;
        wait_ticks(20);
        send_8n1(8'h5C);
        check_outs("after_break", 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of the fourth data bit
        RX = 1'b0;
        wait_ticks(16);
        RX = 1'b1;
        wait_ticks(16);
        RX = 1'b1;
        wait_ticks(16);
        RX = 1'b0;
        wait_ticks(16);
        RX = 1'b0;
        wait_ticks(8);
        @(negedge PCLK);
        PRESET = 1'b1;
        RX = 1'b1;
        #1;
        check_outs("midframe_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge PCLK);
        PRESET = 1'b0;
        wait_ticks(40);
        send_8n1(8'h7E);
        check_outs("after_reset", 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
